memory_access_ctrl: RTL and testbench

MEMORY_ACCESS_CTRL -- requirements
Module: memory_access_ctrl

---
 rtl/memory_access_ctrl_pkg.sv | 15 +
 rtl/memory_access_ctrl_register.sv | 18 +
 rtl/memory_access_ctrl.sv | 121 ++++++++++++
 tb/tb_memory_access_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_ctrl_pkg.sv
// Shared pipeline definitions for the memory stage: FSM state encodings and
// the memory response timeout.
package memory_access_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mac_state_e;

endpackage

// File: rtl/memory_access_ctrl_register.sv
// Generic load-enabled register with synchronous active-high clear.
module memory_access_ctrl_register #(
  parameter int REGISTER_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [REGISTER_WIDTH-1:0] d,
  output logic [REGISTER_WIDTH-1:0] q
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/memory_access_ctrl.sv
// Memory-stage access controller: issues one-cycle memory strobes, waits for
// the response or a timeout, and freezes upstream latches while busy.
module memory_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead_m,
  input  logic        memWrite_m,
  input  logic        halt_m,
  input  logic [15:0] addr_m,
  input  logic [15:0] wrData_m,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  output logic        memRd,
  output logic        memWr,
  output logic        memCreateDump,
  input  logic [15:0] memDataOut,
  input  logic        memDone,
  input  logic        memErr,
  output logic [15:0] readData_m,
  output logic        stall_m,
  output logic        err_m
);
  import memory_access_ctrl_pkg::*;

  mac_state_e        state;
  logic [7:0]        wait_cnt;
  logic              err_flag;
  logic              dumped;
  logic              op_read;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              any_req;
  logic              bad_req;
  logic              good_req;
  logic              fail;
  logic              rd_en;
  logic [DATA_W-1:0] rd_d;

  // Request qualification happens in the same cycle the latch presents it,
  // so upstream sees stall_m before it can advance.
  assign any_req  = memRead_m | memWrite_m;
  assign bad_req  = any_req & (addr_m[0] | (memRead_m & memWrite_m));
  assign good_req = !rst && (state == IDLE) && any_req && !bad_req;

  assign memRd         = good_req & memRead_m;
  assign memWr         = good_req & memWrite_m;
  assign memAddr       = rst ? '0 : (good_req ? addr_m   : addr_q);
  assign memDataIn     = rst ? '0 : (good_req ? wrData_m : data_q);
  assign stall_m       = !rst && (good_req || (state == WAIT));
  assign err_m         = !rst && (((state == IDLE) && bad_req) ||
                                  ((state == DONE) && err_flag));
  assign memCreateDump = !rst && (state == IDLE) && halt_m && !any_req && !dumped;

  // A response on the last allowed wait cycle still counts as success.
  assign fail = memErr || (!memDone && (wait_cnt == MEM_TIMEOUT - 8'd1));

  // NOTE: defaults first so no path through the block can infer a latch.
  always_comb begin
    rd_en = 1'b0;
    rd_d  = memDataOut;
    if (state == WAIT) begin
      if (fail) begin
        rd_en = 1'b1;
        rd_d  = '0;
      end else if (memDone && op_read) begin
        rd_en = 1'b1;
      end
    end
  end

  memory_access_ctrl_register #(
    .REGISTER_WIDTH(DATA_W)
  ) u_read_data (
    .clk (clk),
    .rst (rst),
    .en  (rd_en),
    .d   (rd_d),
    .q   (readData_m)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_flag <= 1'b0;
      dumped   <= 1'b0;
      op_read  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memCreateDump) dumped <= 1'b1;
          if (good_req) begin
            addr_q  <= addr_m;
            data_q  <= wrData_m;
            op_read <= memRead_m;
            state   <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (fail) begin
            err_flag <= 1'b1;
            state    <= DONE;
          end else if (memDone) begin
            state <= DONE;
          end
        end
        DONE: begin
          wait_cnt <= '0;
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Self-checking bench for memory_access_ctrl: directed corner cases plus
// randomized transactions against a transaction-level reference model.
module tb_memory_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead_m, memWrite_m, halt_m;
  logic [15:0] addr_m, wrData_m;
  logic [15:0] memAddr, memDataIn;
  logic        memRd, memWr, memCreateDump;
  logic [15:0] memDataOut;
  logic        memDone, memErr;
  logic [15:0] readData_m;
  logic        stall_m, err_m;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: last value delivered to writeback, dump already issued.
  logic [15:0] ref_rdata;
  bit          ref_dumped;

  always #5 clk = ~clk;

  memory_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .memRead_m     (memRead_m),
    .memWrite_m    (memWrite_m),
    .halt_m        (halt_m),
    .addr_m        (addr_m),
    .wrData_m      (wrData_m),
    .memAddr       (memAddr),
    .memDataIn     (memDataIn),
    .memRd         (memRd),
    .memWr         (memWr),
    .memCreateDump (memCreateDump),
    .memDataOut    (memDataOut),
    .memDone       (memDone),
    .memErr        (memErr),
    .readData_m    (readData_m),
    .stall_m       (stall_m),
    .err_m         (err_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change at posedge+1, outputs are checked at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit halt, input bit noise_done, input bit noise_err);
    memRead_m  = 1'b0;
    memWrite_m = 1'b0;
    halt_m     = halt;
    addr_m     = 16'($urandom);
    wrData_m   = 16'($urandom);
    memDone    = noise_done;
    memErr     = noise_err;
    memDataOut = 16'($urandom);
    @(negedge clk);
    check("idle_dump",  memCreateDump, halt && !ref_dumped);
    check("idle_stall", stall_m, 0);
    check("idle_err",   err_m, 0);
    check("idle_strobe", {memRd, memWr}, 0);
    check("idle_rdata", readData_m, ref_rdata);
    if (halt) ref_dumped = 1'b1;
    next_cycle();
  endtask

  // One access from IDLE. delay = wait cycle (1-based) on which the response
  // arrives; 0 means the memory never answers.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int delay,
                        input bit use_err, input bit use_done,
                        input logic [15:0] rdata, input bit halt);
    bit valid, invalid, finished, exp_err, hit;
    valid   = (rd ^ wr) && !addr[0];
    invalid = (rd || wr) && !valid;
    memRead_m  = rd;
    memWrite_m = wr;
    halt_m     = halt;
    addr_m     = addr;
    wrData_m   = wdata;
    memDone    = 1'($urandom);
    memErr     = 1'($urandom);
    memDataOut = 16'($urandom);
    @(negedge clk);
    check("req_rd",    memRd, valid && rd);
    check("req_wr",    memWr, valid && wr);
    check("req_stall", stall_m, valid);
    check("req_err",   err_m, invalid);
    check("req_dump",  memCreateDump, 0);
    check("req_rdata", readData_m, ref_rdata);
    if (valid) begin
      check("req_addr", memAddr, addr);
      check("req_wdat", memDataIn, wdata);
    end
    next_cycle();
    if (!valid) return;

    finished = 1'b0;
    for (int k = 1; k <= 255 && !finished; k++) begin
      hit        = (k == delay);
      memDone    = hit && use_done;
      memErr     = hit && use_err;
      memDataOut = hit ? rdata : 16'($urandom);
      @(negedge clk);
      check("wait_stall",  stall_m, 1);
      check("wait_strobe", {memRd, memWr}, 0);
      check("wait_err",    err_m, 0);
      check("wait_addr",   memAddr, addr);
      check("wait_wdat",   memDataIn, wdata);
      check("wait_rdata",  readData_m, ref_rdata);
      if (hit && (use_done || use_err)) finished = 1'b1;
      next_cycle();
    end

    exp_err = finished ? use_err : 1'b1;
    if (exp_err)  ref_rdata = 16'h0000;
    else if (rd)  ref_rdata = rdata;

    memDone    = 1'($urandom);
    memErr     = 1'($urandom);
    memDataOut = 16'($urandom);
    @(negedge clk);
    check("done_stall",  stall_m, 0);
    check("done_err",    err_m, exp_err);
    check("done_strobe", {memRd, memWr}, 0);
    check("done_rdata",  readData_m, ref_rdata);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    memRead_m = 1'b0; memWrite_m = 1'b0; halt_m = 1'b0;
    addr_m = '0; wrData_m = '0;
    memDataOut = '0; memDone = 1'b0; memErr = 1'b0;
    ref_rdata = 16'h0000;
    ref_dumped = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    @(negedge clk);
    check("rst_rdata", readData_m, 0);
    check("rst_ctrl",  {memRd, memWr, memCreateDump, stall_m, err_m}, 0);
    check("rst_addr",  memAddr, 0);
    check("rst_wdat",  memDataIn, 0);
    next_cycle();

    // Load, response two cycles after the request.
    access(1, 0, 16'h0010, 16'h0000, 2, 0, 1, 16'hBEEF, 0);
    // Store, response on the first wait cycle; readData must keep 0xBEEF.
    access(0, 1, 16'h0020, 16'h1234, 1, 0, 1, 16'h5555, 0);
    // Misaligned load and read+write conflict.
    access(1, 0, 16'h0011, 16'h0000, 1, 0, 1, 16'h7777, 0);
    access(1, 1, 16'h0030, 16'h0000, 1, 0, 1, 16'h7777, 0);
    // Halt held five cycles: exactly one dump pulse.
    for (int i = 0; i < 5; i++) idle_cycle(1, 0, 0);
    // Timeout, then error and done together.
    access(1, 0, 16'h0050, 16'h0000, 0, 0, 0, 16'h0000, 0);
    access(1, 0, 16'h0052, 16'h0000, 3, 0, 1, 16'hC0DE, 0);
    access(1, 0, 16'h0060, 16'h0000, 3, 1, 1, 16'hAAAA, 0);

    for (int t = 0; t < 60; t++) begin
      int sel;
      bit rd, wr, ue, ud;
      logic [15:0] a;
      sel = $urandom_range(0, 9);
      rd  = (sel == 0) || (sel <= 4) || (sel == 9);
      wr  = (sel == 0) || (sel >= 5 && sel <= 8);
      a   = 16'($urandom);
      a[0] = ($urandom_range(0, 4) == 0);
      ue  = ($urandom_range(0, 7) == 0);
      ud  = ue ? 1'($urandom) : 1'b1;
      access(rd, wr, a, 16'($urandom), $urandom_range(1, 6), ue, ud,
             16'($urandom), 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--)
        idle_cycle($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom));
    end

    // Make readData nonzero, then reset in the middle of a wait.
    access(1, 0, 16'h0070, 16'h0000, 1, 0, 1, 16'h9A5C, 0);
    memRead_m = 1'b1; memWrite_m = 1'b0; halt_m = 1'b0;
    addr_m = 16'h0080; memDone = 1'b0; memErr = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    memRead_m = 1'b0;
    memDone = 1'b1;
    memDataOut = 16'hDEAD;
    ref_rdata = 16'h0000;
    ref_dumped = 1'b0;
    @(negedge clk);
    check("mid_rst_ctrl",  {memRd, memWr, memCreateDump, stall_m, err_m}, 0);
    check("mid_rst_addr",  memAddr, 0);
    check("mid_rst_wdat",  memDataIn, 0);
    check("mid_rst_rdata", readData_m, 0);
    next_cycle();
    idle_cycle(0, 1, 0);
    idle_cycle(1, 0, 0);
    idle_cycle(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
